// File: rtl/rtc_addr_shadow_mem_if.sv
// RTC bus transaction channel between the bus controller (master) and the
// address translator / shadow file (slave).
interface rtc_addr_shadow_mem_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int IDX_W  = 4
);
    logic              bus_valid;
    logic              bus_ready;
    logic              bus_we;
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_data;
    logic              idx_valid;
    logic [IDX_W-1:0]  idx_out;
    logic              idx_hit;

    modport master (
        output bus_valid, bus_we, bus_addr, bus_data,
        input  bus_ready, idx_valid, idx_out, idx_hit
    );

    modport slave (
        input  bus_valid, bus_we, bus_addr, bus_data,
        output bus_ready, idx_valid, idx_out, idx_hit
    );
endinterface

// File: rtl/rtc_addr_shadow_mem.sv
// RTC address translator: maps the time and timer windows onto dense shadow
// indices, keeps a shadow copy of written data with dirty flags, counts misses.
module rtc_addr_shadow_mem #(
    parameter int                ADDR_W     = 8,
    parameter int                DATA_W     = 8,
    parameter logic [ADDR_W-1:0] TIME_BASE  = 8'h21,
    parameter int                N_TIME     = 7,
    parameter logic [ADDR_W-1:0] TIMER_BASE = 8'h41,
    parameter int                N_TIMER    = 3,
    parameter int                DEPTH      = N_TIME + N_TIMER,
    parameter int                IDX_W      = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    rtc_addr_shadow_mem_if.slave bus,
    output logic [7:0]           miss_cnt,
    input  logic [IDX_W-1:0]     rd_idx,
    output logic [DATA_W-1:0]    rd_data,
    output logic [DEPTH-1:0]     dirty,
    input  logic [DEPTH-1:0]     clr_dirty,
    input  logic                 clr_all,
    output logic                 busy
);
    localparam logic [IDX_W-1:0]  INVALID   = '1;
    localparam logic [IDX_W-1:0]  LAST      = IDX_W'(DEPTH - 1);
    localparam logic [IDX_W-1:0]  DEPTH_I   = IDX_W'(DEPTH);
    localparam logic [ADDR_W:0]   TIME_END  = {1'b0, TIME_BASE} + (ADDR_W+1)'(N_TIME);
    localparam logic [ADDR_W:0]   TIMER_END = {1'b0, TIMER_BASE} + (ADDR_W+1)'(N_TIMER);

    typedef enum logic {CLEAR, RUN} state_t;

    // Returns {hit, index}; window bounds compared one bit wider so BASE+N cannot wrap.
    function automatic logic [IDX_W:0] translate(input logic [ADDR_W-1:0] addr);
        logic [ADDR_W:0] a;
        a = {1'b0, addr};
        if (a >= {1'b0, TIME_BASE} && a < TIME_END)
            return {1'b1, IDX_W'(addr - TIME_BASE)};
        if (a >= {1'b0, TIMER_BASE} && a < TIMER_END)
            return {1'b1, IDX_W'(N_TIME) + IDX_W'(addr - TIMER_BASE)};
        return {1'b0, INVALID};
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    state_t           state;
    logic [IDX_W-1:0] ptr;
    logic             ready_r;
    logic             vld_p1;
    logic [IDX_W-1:0] idx_p1;
    logic             hit_p1;
    logic [DATA_W-1:0] shadow [DEPTH];

    // Stage 0: acceptance and combinational translation of the bus inputs
    logic             acc_p0;
    logic [IDX_W:0]   xl_p0;
    logic             hit_p0;
    logic [IDX_W-1:0] idx_p0;
    logic             wr_p0;
    logic [DEPTH-1:0] set_mask_p0;

    assign acc_p0 = bus.bus_valid & ready_r;
    assign xl_p0  = translate(bus.bus_addr);
    assign hit_p0 = xl_p0[IDX_W];
    assign idx_p0 = xl_p0[IDX_W-1:0];
    // A write accepted together with clr_all is dropped; the sweep would erase it anyway.
    assign wr_p0  = acc_p0 & hit_p0 & bus.bus_we & ~clr_all & ~reset;

    always_comb begin
        set_mask_p0 = '0;
        if (wr_p0) set_mask_p0[idx_p0] = 1'b1;
    end

    // Stage 1: registered translation result, counters, control FSM
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= CLEAR;
            ptr      <= '0;
            ready_r  <= 1'b0;
            busy     <= 1'b1;
            vld_p1   <= 1'b0;
            idx_p1   <= INVALID;
            hit_p1   <= 1'b0;
            miss_cnt <= '0;
            rd_data  <= '0;
            dirty    <= '0;
        end else begin
            vld_p1  <= acc_p0;
            rd_data <= (rd_idx < DEPTH_I) ? shadow[rd_idx] : '0;
            if (acc_p0) begin
                idx_p1 <= idx_p0;
                hit_p1 <= hit_p0;
                if (!hit_p0) miss_cnt <= sat_inc(miss_cnt);
            end
            case (state)
                CLEAR: begin
                    dirty <= '0;
                    if (clr_all) begin
                        ptr <= '0;
                    end else if (ptr == LAST) begin
                        state   <= RUN;
                        busy    <= 1'b0;
                        ready_r <= 1'b1;
                    end else begin
                        ptr <= ptr + 1'b1;
                    end
                end
                RUN: begin
                    if (clr_all) begin
                        state   <= CLEAR;
                        ptr     <= '0;
                        busy    <= 1'b1;
                        ready_r <= 1'b0;
                        dirty   <= '0;
                    end else begin
                        dirty <= (dirty & ~clr_dirty) | set_mask_p0;
                    end
                end
                default: state <= CLEAR;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state == CLEAR)
                shadow[ptr] <= '0;
            else if (wr_p0)
                shadow[idx_p0] <= bus.bus_data;
        end
    end

    assign bus.bus_ready = ready_r;
    assign bus.idx_valid = vld_p1;
    assign bus.idx_out   = idx_p1;
    assign bus.idx_hit   = hit_p1;
endmodule
